// File: rtl/bytes_to_bits_collect.sv
// Byte-to-bit-vector collector: gathers BYTE_LENGTH bytes little-endian into one frame.
// Optional running XOR checksum output enabled by BYTES_TO_BITS_COLLECT_XSUM_EN.
module bytes_to_bits_collect #(
    parameter  int BIT_LENGTH  = 2048,
    localparam int BYTE_LENGTH = BIT_LENGTH / 8,
    localparam int CNT_W       = $clog2(BYTE_LENGTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIT_LENGTH-1:0] bit_array,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef BYTES_TO_BITS_COLLECT_XSUM_EN
    output logic [7:0]            xsum,
`endif
    output logic [CNT_W-1:0]      byte_count
);

    if ((BIT_LENGTH % 8) != 0 || BIT_LENGTH < 16) begin : g_bad_length
        $error("bytes_to_bits_collect: BIT_LENGTH must be a multiple of 8 and at least 16");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FULL
    } state_t;

    state_t                state_q, state_d;
    logic [BIT_LENGTH-1:0] bits_q, bits_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  accept;
    logic                  last_byte;
    logic                  handoff;
`ifdef BYTES_TO_BITS_COLLECT_XSUM_EN
    logic [7:0]            xsum_q, xsum_d;
`endif

    // in_ready depends only on registered state, never on in_valid
    assign in_ready  = (state_q != S_FULL);
    assign accept    = in_valid && in_ready;
    assign last_byte = (cnt_q == CNT_W'(BYTE_LENGTH - 1));
    assign handoff   = valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
`ifdef BYTES_TO_BITS_COLLECT_XSUM_EN
        xsum_d  = xsum_q;
`endif
        if (clear) begin
            // Flush wins over a same-cycle byte and over a same-cycle handoff
            state_d = S_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
`ifdef BYTES_TO_BITS_COLLECT_XSUM_EN
            xsum_d  = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_FILL: begin
                    if (accept) begin
                        for (int i = 0; i < BYTE_LENGTH; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                bits_d[8*i +: 8] = in_byte;
                            end
                        end
                        cnt_d = cnt_q + 1'b1;
`ifdef BYTES_TO_BITS_COLLECT_XSUM_EN
                        xsum_d = xsum_q ^ in_byte;
`endif
                        if (last_byte) begin
                            state_d = S_FULL;
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_FILL;
                        end
                    end
                end
                S_FULL: begin
                    // bit_array keeps stale contents after handoff
                    if (handoff) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        valid_d = 1'b0;
`ifdef BYTES_TO_BITS_COLLECT_XSUM_EN
                        xsum_d  = '0;
`endif
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            bits_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
`ifdef BYTES_TO_BITS_COLLECT_XSUM_EN
            xsum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
`ifdef BYTES_TO_BITS_COLLECT_XSUM_EN
            xsum_q  <= xsum_d;
`endif
        end
    end

    assign bit_array  = bits_q;
    assign out_valid  = valid_q;
    assign byte_count = cnt_q;
`ifdef BYTES_TO_BITS_COLLECT_XSUM_EN
    assign xsum       = xsum_q;
`endif

endmodule
